mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 22 ++
 rtl/mem_access_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the load/store access controller.
// The controller issues requests; memory returns grant, ack and read data.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between execute stage and data memory.
// Checks legality and alignment, runs the request/response handshake.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        d_r_en,
  input  logic        d_w_en,
  input  logic [31:0] d_add,
  input  logic [2:0]  f3,
  input  logic [31:0] ALU_out,
  input  logic [4:0]  alu_rd,
  mem_access_ctrl_if.master mem,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] add_q;
  logic [2:0]  f3_q;
  logic [31:0] data_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic        mis_q, to_q;

  logic illegal, misal, any_en;
  logic take, cap, mis_fire, to_fire;

  assign any_en  = d_r_en | d_w_en;
  assign illegal = (d_r_en & d_w_en)
                 | (f3[1:0] == 2'b11)
                 | (d_r_en & (f3 == 3'b110))
                 | (d_w_en & f3[2]);
  assign misal   = ((f3[1:0] == 2'b01) & d_add[0])
                 | ((f3[1:0] == 2'b10) & (d_add[1:0] != 2'b00));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    take     = 1'b0;
    cap      = 1'b0;
    mis_fire = 1'b0;
    to_fire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_valid & any_en) begin
          if (illegal | misal) begin
            mis_fire = 1'b1;
          end else begin
            take    = 1'b1;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.mem_gnt & mem.mem_rvalid) begin
          cap     = 1'b1;
          state_d = RESP;
        end else if (mem.mem_gnt) begin
          state_d = WAIT;
        end else if (cnt_d >= TO_LIM) begin
          to_fire = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.mem_rvalid) begin
          cap     = 1'b1;
          state_d = RESP;
        end else if (cnt_d >= TO_LIM) begin
          to_fire = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      add_q   <= '0;
      f3_q    <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_fire;
      to_q    <= to_fire;
      if (take) begin
        add_q  <= d_add;
        f3_q   <= f3;
        data_q <= ALU_out;
        rd_q   <= alu_rd;
        we_q   <= d_w_en;
      end
      if (cap) rdata_q <= mem.mem_rdata;
    end
  end

  logic        in_req, in_ld_resp, sx;
  logic [3:0]  be_w;
  logic [31:0] wdata_w, sh, ld_val;

  assign in_req     = (state_q == REQ) & ~rst;
  assign in_ld_resp = (state_q == RESP) & ~we_q & ~rst;
  assign sx         = ~f3_q[2];

  always_comb begin
    sh = rdata_q >> {add_q[1:0], 3'b000};
    unique case (f3_q[1:0])
      2'b00: begin
        be_w    = 4'b0001 << add_q[1:0];
        wdata_w = {4{data_q[7:0]}};
        ld_val  = {{24{sx & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        be_w    = 4'b0011 << add_q[1:0];
        wdata_w = {2{data_q[15:0]}};
        ld_val  = {{16{sx & sh[15]}}, sh[15:0]};
      end
      default: begin
        be_w    = 4'b1111;
        wdata_w = data_q;
        ld_val  = sh;
      end
    endcase
  end

  assign ex_ready      = (state_q == IDLE) & ~rst;
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & we_q;
  assign mem.mem_addr  = in_req ? {add_q[31:2], 2'b00} : '0;
  assign mem.mem_be    = in_req ? be_w : '0;
  assign mem.mem_wdata = in_req ? wdata_w : '0;

  // rd==0 loads still complete the handshake but never write back
  assign wb_en   = in_ld_resp & (rd_q != 5'd0);
  assign wb_rd   = in_ld_resp ? rd_q : '0;
  assign wb_data = in_ld_resp ? ld_val : '0;

  assign misalign_err = mis_q & ~rst;
  assign timeout_err  = to_q & ~rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-lane reference model.
// Memory timing is driven per transaction from random grant/response delays.
module tb_mem_access_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, d_r_en, d_w_en;
  logic [31:0] d_add, alu_out;
  logic [2:0]  f3;
  logic [4:0]  alu_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err, timeout_err;
  int n_chk = 0;
  int n_fail = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .d_r_en(d_r_en), .d_w_en(d_w_en),
    .d_add(d_add), .f3(f3), .ALU_out(alu_out), .alu_rd(alu_rd),
    .mem(bus),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [110:0] all_out();
    return {ex_ready, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be,
            bus.mem_wdata, wb_en, wb_rd, wb_data, misalign_err, timeout_err};
  endfunction

  // reference model: access size in bytes, lane arithmetic
  function automatic int nbytes(input logic [2:0] f);
    case (f[1:0])
      2'b00: return 1;
      2'b01: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ref_err(input bit ld, input bit st,
                                 input logic [2:0] f, input logic [31:0] a);
    if (!ld && !st) return 1'b0;
    if (ld && st) return 1'b1;
    if (f[1:0] == 2'b11) return 1'b1;
    if (ld && f == 3'b110) return 1'b1;
    if (st && f[2]) return 1'b1;
    return (a % nbytes(f)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(f)) - 1) << int'(a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] v);
    logic [31:0] r;
    int n;
    n = nbytes(f);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] w);
    longint x;
    longint span;
    int n;
    n = nbytes(f);
    span = longint'(1) << (8 * n);
    x = longint'({32'd0, w}) >> (8 * int'(a % 4));
    x = x % span;
    if (n < 4 && !f[2] && x >= span / 2) x = x - span;
    return 32'(x);
  endfunction

  task automatic do_access(input string nm, input bit ld, input bit st,
                           input logic [31:0] a, input logic [2:0] f,
                           input logic [31:0] v, input logic [4:0] rd,
                           input int gd, input int rv, input logic [31:0] rw);
    int resp;
    bit err;
    logic [69:0] exp_m;
    logic [31:0] exp_d;
    err = ref_err(ld, st, f, a);
    n_chk++;
    if (ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before got=%b want=1", nm, ex_ready);
    end
    ex_valid = 1'b1; d_r_en = ld; d_w_en = st;
    d_add = a; f3 = f; alu_out = v; alu_rd = rd;
    step();
    ex_valid = 1'b0; d_r_en = 1'($urandom); d_w_en = 1'($urandom);
    d_add = $urandom; f3 = 3'($urandom); alu_out = $urandom; alu_rd = 5'($urandom);
    if (!ld && !st) begin
      n_chk++;
      if ({ex_ready, bus.mem_req, misalign_err, wb_en} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s nop got=%b want=1000", nm,
                 {ex_ready, bus.mem_req, misalign_err, wb_en});
      end
      return;
    end
    if (err) begin
      n_chk++;
      if ({ex_ready, bus.mem_req, misalign_err, wb_en, timeout_err} !== 5'b10100) begin
        n_fail++;
        $display("FAIL %s misalign_pulse got=%b want=10100", nm,
                 {ex_ready, bus.mem_req, misalign_err, wb_en, timeout_err});
      end
      step();
      n_chk++;
      if ({ex_ready, bus.mem_req, misalign_err} !== 3'b100) begin
        n_fail++;
        $display("FAIL %s misalign_drop got=%b want=100", nm,
                 {ex_ready, bus.mem_req, misalign_err});
      end
      return;
    end
    resp  = gd + rv + 2;
    exp_m = {1'b1, st, a[31:2], 2'b00, ref_be(f, a), ref_wdata(f, v)};
    exp_d = ref_load(f, a, rw);
    for (int t = 1; t <= resp + 1; t++) begin
      n_chk++;
      if (t <= gd + 1) begin
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== exp_m) begin
          n_fail++;
          $display("FAIL %s req t=%0d got=%h want=%h", nm, t,
                   {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}, exp_m);
        end
      end else if (bus.mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL %s req_low t=%0d got=%b want=0", nm, t, bus.mem_req);
      end
      n_chk++;
      if ({ex_ready, wb_en, misalign_err, timeout_err} !==
          {t == resp + 1, t == resp && ld && rd != 0, 2'b00}) begin
        n_fail++;
        $display("FAIL %s ctl t=%0d got=%b want=%b", nm, t,
                 {ex_ready, wb_en, misalign_err, timeout_err},
                 {t == resp + 1, t == resp && ld && rd != 0, 2'b00});
      end
      if (t == resp && ld) begin
        n_chk++;
        if ({wb_rd, wb_data} !== {rd, exp_d}) begin
          n_fail++;
          $display("FAIL %s wb got=%0d/%h want=%0d/%h", nm, wb_rd, wb_data, rd, exp_d);
        end
      end
      if (t == resp + 1) break;
      bus.mem_gnt    = (t == gd + 1);
      bus.mem_rvalid = (t == gd + 1 + rv);
      bus.mem_rdata  = (t == gd + 1 + rv) ? rw : $urandom;
      if (t == resp) begin
        bus.mem_gnt    = 1'($urandom);
        bus.mem_rvalid = 1'($urandom);
      end
      step();
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_chk++;
    if (all_out() !== '0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h want=0", all_out());
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (all_out() !== {1'b1, 110'd0}) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", all_out(), {1'b1, 110'd0});
    end
  endtask

  task automatic test_directed();
    do_access("lb_0x103", 1, 0, 32'h103, 3'b000, 32'h0, 5'd5, 0, 0, 32'h80FFFFFF);
    do_access("sh_0x202", 0, 1, 32'h202, 3'b001, 32'h1234ABCD, 5'd1, 2, 1, 32'h0);
    do_access("lw_mis", 1, 0, 32'h6, 3'b010, 32'h0, 5'd2, 0, 0, 32'h0);
    do_access("lhu_0x6", 1, 0, 32'h6, 3'b101, 32'h0, 5'd7, 1, 0, 32'hBEEF0000);
    do_access("lw_rd0", 1, 0, 32'h10, 3'b010, 32'h0, 5'd0, 0, 2, 32'hCAFEF00D);
    do_access("lh_neg", 1, 0, 32'h22, 3'b001, 32'h0, 5'd3, 0, 0, 32'h9ABC0000);
    do_access("lbu_1", 1, 0, 32'h31, 3'b100, 32'h0, 5'd4, 0, 0, 32'h0000F100);
    do_access("sb_3", 0, 1, 32'h43, 3'b000, 32'hA5A5A57E, 5'd0, 0, 0, 32'h0);
    do_access("sw_mis", 0, 1, 32'h13, 3'b010, 32'h1, 5'd0, 0, 0, 32'h0);
    do_access("sh_mis", 0, 1, 32'h1, 3'b001, 32'h1, 5'd0, 0, 0, 32'h0);
    do_access("both_en", 1, 1, 32'h0, 3'b010, 32'h1, 5'd1, 0, 0, 32'h0);
    do_access("f3_11", 1, 0, 32'h0, 3'b011, 32'h1, 5'd1, 0, 0, 32'h0);
    do_access("lwu", 1, 0, 32'h0, 3'b110, 32'h1, 5'd1, 0, 0, 32'h0);
    do_access("sbu", 0, 1, 32'h0, 3'b100, 32'h1, 5'd1, 0, 0, 32'h0);
    do_access("nop", 0, 0, 32'h7, 3'b010, 32'h1, 5'd1, 0, 0, 32'h0);
  endtask

  task automatic test_timeout(input bit grant);
    ex_valid = 1'b1; d_r_en = 1'b1; d_w_en = 1'b0;
    d_add = 32'h40; f3 = 3'b010; alu_rd = 5'd3;
    step();
    ex_valid = 1'b0; d_r_en = 1'b0;
    for (int t = 1; t <= TO + 3; t++) begin
      n_chk++;
      if ({bus.mem_req, timeout_err, wb_en, ex_ready} !==
          {grant ? t == 1 : t <= TO, t == TO + 1, 1'b0, t > TO}) begin
        n_fail++;
        $display("FAIL timeout g=%0d t=%0d got=%b want=%b", grant, t,
                 {bus.mem_req, timeout_err, wb_en, ex_ready},
                 {grant ? t == 1 : t <= TO, t == TO + 1, 1'b0, t > TO});
      end
      bus.mem_gnt    = grant && t == 1;
      bus.mem_rvalid = (t == TO + 2);
      bus.mem_rdata  = 32'h1234_5678;
      step();
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_idle_stray();
    for (int i = 0; i < 6; i++) begin
      bus.mem_gnt = 1'($urandom);
      bus.mem_rvalid = 1'($urandom);
      bus.mem_rdata = $urandom;
      step();
      n_chk++;
      if ({ex_ready, bus.mem_req, wb_en, misalign_err, timeout_err} !== 5'b10000) begin
        n_fail++;
        $display("FAIL idle_stray i=%0d got=%b want=10000", i,
                 {ex_ready, bus.mem_req, wb_en, misalign_err, timeout_err});
      end
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    ex_valid = 1'b1; d_r_en = 1'b1; d_w_en = 1'b0;
    d_add = 32'h80; f3 = 3'b010; alu_rd = 5'd9;
    step();
    ex_valid = 1'b0; d_r_en = 1'b0;
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    n_chk++;
    if ({bus.mem_req, ex_ready, wb_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL wait_state got=%b want=000", {bus.mem_req, ex_ready, wb_en});
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (all_out() !== '0) begin
      n_fail++;
      $display("FAIL rst_comb got=%h want=0", all_out());
    end
    step();
    n_chk++;
    if (all_out() !== '0) begin
      n_fail++;
      $display("FAIL rst_in_wait got=%h want=0", all_out());
    end
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hFFFF;
    step();
    bus.mem_rvalid = 1'b0;
    n_chk++;
    if ({ex_ready, wb_en, bus.mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL post_rst got=%b want=100", {ex_ready, wb_en, bus.mem_req});
    end
    do_access("post_rst_lw", 1, 0, 32'h84, 3'b010, 32'h0, 5'd9, 1, 0, 32'h13579BDF);
  endtask

  task automatic test_random();
    bit ld, st;
    int k;
    logic [2:0] f;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      ld = (k == 1) || (k >= 2 && k <= 5);
      st = (k == 1) || (k >= 6);
      f = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f) - 1);
      do_access("rand", ld, st, a, f, $urandom, 5'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; d_r_en = 1'b0; d_w_en = 1'b0;
    d_add = '0; f3 = '0; alu_out = '0; alu_rd = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_directed();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_idle_stray();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
